dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back, one-word-per-line data cache controller placed between the CPU memory stage and the word-addressed synchronous data RAM. It serves hits from an internal line array in the request cycle. It sequences victim write-back and line refill against the RAM, whose read data is registered and appears one cycle after the address. It also keeps hit and miss statistics counters.

## Interface
- INDEX_WIDTH, 3 — line index width; 2^INDEX_WIDTH lines; tag = addr[31:INDEX_WIDTH]
- clk  input  1  — single clock; all state updates on rising edge
- rst  input  1  — asynchronous, active-high reset
- cpu_req  input  1  — access request; held with addr/we/din stable until cpu_ack
- cpu_we  input  1  — 1 = write word, 0 = read word
- cpu_addr  input  32  — word address
- cpu_din  input  32  — write data
- cpu_dout  output  32  — read data, valid only while cpu_ack=1; 0 otherwise
- cpu_ack  output  1  — one-cycle completion strobe
- mem_we  output  1  — RAM write enable
- mem_addr  output  32  — RAM word address
- mem_din  output  32  — RAM write data
- mem_dout  input  32  — RAM read data; reflects mem_addr registered at the previous edge
- hit_cnt  output  32  — completed hits, wraps at 2^32
- miss_cnt  output  32  — completed misses, wraps at 2^32

## Operation
- Per line: valid, dirty, tag[31-INDEX_WIDTH:0], data[31:0]. idx = cpu_addr[INDEX_WIDTH-1:0].
- hit = cpu_req & valid[idx] & (tag[idx] == cpu_addr[31:INDEX_WIDTH]).
- FSM states: IDLE, WB, FILL, REFILL.
- IDLE:
  - On hit: cpu_ack=1 combinationally.
  - Read hit: cpu_dout = data[idx].
  - Write hit: data[idx] <= cpu_din and dirty[idx] <= 1 at the edge.
  - hit_cnt increments on every hit.
  - Miss with valid & dirty victim -> WB; other misses -> FILL.
  - With cpu_req=0: no action.
- WB (1 cycle):
  - mem_we=1, mem_addr = {tag[idx], idx}, mem_din = data[idx].
  - -> FILL.
- FILL (1 cycle): mem_we=0, mem_addr=cpu_addr; -> REFILL.
- REFILL (1 cycle):
  - mem_addr=cpu_addr, mem_we=0, cpu_ack=1.
  - Line update: valid=1, tag = cpu_addr[31:INDEX_WIDTH].
  - Read miss: data = mem_dout, dirty=0, cpu_dout = mem_dout.
  - Write miss: data = cpu_din, dirty=1, cpu_dout = 0 (write-allocate, fetched word discarded).
  - miss_cnt increments; -> IDLE.
- Outside WB/FILL/REFILL: mem_we=0, mem_addr=0, mem_din=0.
- Addresses the RAM does not decode are cached normally. Such addresses read as 0 from RAM and their write-backs are dropped by the RAM; the controller does not special-case them.
- Dropping cpu_req before cpu_ack is a protocol violation. Behaviour in that case is undefined, except that the FSM always completes back to IDLE.

## Timing
- Reset (async, immediate):
  - state=IDLE; all valid=0 and dirty=0; hit_cnt=0, miss_cnt=0.
  - cpu_ack=0, cpu_dout=0, mem_we=0, mem_addr=0, mem_din=0.
  - Tag and data arrays need not be cleared.
- Reset mid-miss: abort to IDLE with no ack. Dirty data not yet written back is lost.
- Hit latency: 0 cycles, ack in the request cycle.
- Clean miss: ack in cycle 2 (request cycle = 0).
- Dirty miss: ack in cycle 3. The RAM write happens at the end of cycle 1.
- The cycle after any ack is IDLE. A new request there is evaluated against updated line state, so back-to-back accesses to the same line hit.
- Counters update at the same edge that ends the ack cycle. They are never incremented simultaneously.

## Test plan
- Reset, then read addr 0x5 (RAM[5]=0xA5A5A5A5) -> miss: FILL mem_addr=5, ack in cycle 2, cpu_dout=0xA5A5A5A5, miss_cnt=1. Repeat read -> ack in cycle 0, hit_cnt=1.
- Write 0x11223344 to addr 0x3 (miss), then read 0x3 -> second access hits with 0x11223344. RAM[3] is unchanged (mem_we never high).
- Dirty eviction, INDEX_WIDTH=3: write 0xDEADBEEF to 0x2, then read 0xA (same index) -> WB cycle with mem_we=1, mem_addr=0x2, mem_din=0xDEADBEEF. Ack in cycle 3 with RAM[0xA] data; afterwards RAM[2]=0xDEADBEEF.
- Clean eviction: read 0x4, then read 0xC -> no WB state, ack in cycle 2, miss_cnt=2.
- Assert rst during the FILL cycle of a dirty-victim miss -> no ack; all outputs 0. The next read of the prior hit address misses.
- Preload hit_cnt to 0xFFFFFFFF via hierarchical force, then do one hit -> hit_cnt=0.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// CPU-side and RAM-side signal bundle for the data cache controller.
// slave is the controller's view; master is the CPU/RAM environment's view.
interface dcache_ctrl_if;
    // cpu_req is held with cpu_we/cpu_addr/cpu_din stable until the single-cycle
    // cpu_ack strobe; cpu_dout is meaningful only while cpu_ack is high.
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_ack;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
        output cpu_dout, cpu_ack, mem_we, mem_addr, mem_din, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
        input  cpu_dout, cpu_ack, mem_we, mem_addr, mem_din, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, one-word-per-line data cache controller with
// hit/miss statistics. Hits complete in the request cycle; misses sequence WB/FILL/REFILL.
module dcache_ctrl #(
    parameter int INDEX_WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int LINES = 2 ** INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL   = 2'd2,
        REFILL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        hit_cnt_q, miss_cnt_q;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   hit_inc, miss_inc;
    logic                   line_wr, line_dirty;
    logic [31:0]            line_data;

    assign idx     = bus.cpu_addr[INDEX_WIDTH-1:0];
    assign req_tag = bus.cpu_addr[31:INDEX_WIDTH];
    assign hit     = bus.cpu_req & valid_q[idx] & (tag_q[idx] == req_tag);

    assign dbg_state    = state_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;

    always_comb begin
        state_d      = state_q;
        bus.cpu_ack  = 1'b0;
        bus.cpu_dout = 32'd0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_din  = 32'd0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        line_wr      = 1'b0;
        line_dirty   = 1'b0;
        line_data    = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    bus.cpu_ack = 1'b1;
                    hit_inc     = 1'b1;
                    if (bus.cpu_we) begin
                        line_wr    = 1'b1;
                        line_dirty = 1'b1;
                        line_data  = bus.cpu_din;
                    end else begin
                        bus.cpu_dout = data_q[idx];
                    end
                end else if (bus.cpu_req) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
                end
            end
            WB: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = {tag_q[idx], idx};
                bus.mem_din  = data_q[idx];
                state_d      = FILL;
            end
            FILL: begin
                bus.mem_addr = bus.cpu_addr;
                state_d      = REFILL;
            end
            REFILL: begin
                // RAM data for the address issued in FILL is available now.
                bus.mem_addr = bus.cpu_addr;
                bus.cpu_ack  = 1'b1;
                miss_inc     = 1'b1;
                line_wr      = 1'b1;
                if (bus.cpu_we) begin
                    line_dirty = 1'b1;
                    line_data  = bus.cpu_din;
                end else begin
                    line_data    = bus.mem_dout;
                    bus.cpu_dout = bus.mem_dout;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (line_wr) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= line_dirty;
            end
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    // Tag/data contents are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= line_data;
        end
    end
endmodule
